hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core: consumes the per-instruction read/write register addresses and Tuse/Tnew values produced by the D-stage address/time decoder, tracks in-flight writers through E/M/W, and issues stall and forwarding-select signals. Also sequences the multiply/divide unit with a busy counter so HI/LO consumers wait for completion. Sits beside the D-stage decoder; drives PC/FD-register enables, the E-stage bubble, and all forwarding muxes.

---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/hazard_ctrl_if.sv | 27 ++
 rtl/hazard_ctrl_md_busy_cnt.sv | 25 ++
 rtl/hazard_ctrl.sv | 77 +++++++
 tb/tb_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: forwarding select codes, mult/div op codes and per-stage tracking records.
package hazard_ctrl_pkg;
    typedef enum logic [1:0] {FWD_GRF = 2'd0, FWD_E = 2'd1, FWD_M = 2'd2, FWD_W = 2'd3} fwd_t;
    typedef enum logic [1:0] {MD_NONE = 2'd0, MD_MULT = 2'd1, MD_DIV = 2'd2, MD_RSVD = 2'd3} md_op_t;
    localparam logic [2:0] TUSE_NEVER = 3'd7;
    typedef struct packed {
        logic [4:0] waddr;
        logic [2:0] tnew;
        logic [4:0] raddr0;
        logic [4:0] raddr1;
    } e_stage_t;
    typedef struct packed {
        logic [4:0] waddr;
        logic [2:0] tnew;
        logic [4:0] raddr1;
    } m_stage_t;
    function automatic logic [2:0] dec_sat(input logic [2:0] t);
        return t == 3'd0 ? 3'd0 : t - 3'd1;
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: D-stage hazard descriptors in, stall/forward/mult-div controls out.
interface hazard_ctrl_if;
    logic [4:0] d_raddr0;
    logic [4:0] d_raddr1;
    logic [2:0] d_tuse0;
    logic [2:0] d_tuse1;
    logic [4:0] d_waddr;
    logic [2:0] d_tnew;
    logic [1:0] d_md_op;
    logic       d_md_use;
    logic       stall;
    logic [1:0] fwd_d_rs;
    logic [1:0] fwd_d_rt;
    logic [1:0] fwd_e_rs;
    logic [1:0] fwd_e_rt;
    logic [1:0] fwd_m_rt;
    logic       md_start;
    logic       md_busy;
    modport master (
        output d_raddr0, d_raddr1, d_tuse0, d_tuse1, d_waddr, d_tnew, d_md_op, d_md_use,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_start, md_busy
    );
    modport slave (
        input  d_raddr0, d_raddr1, d_tuse0, d_tuse1, d_waddr, d_tnew, d_md_op, d_md_use,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_start, md_busy
    );
endinterface

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// md_busy_cnt: mult/div busy counter; loads the op latency on start and counts down to idle.
module md_busy_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    output logic       busy
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (start)
            cnt <= op == MD_DIV ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end
    assign busy = cnt != '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Tuse/Tnew stall and forwarding control for the five-stage pipeline.
// Define HAZARD_MD_EN to add the mult/div busy counter, md_start and the HI/LO stall.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);
    e_stage_t   e;
    m_stage_t   m;
    logic [4:0] w_waddr;
    logic       data_stall;
    logic       md_stall;

    function automatic logic op_stall(input logic [4:0] r, input logic [2:0] tuse,
                                      input e_stage_t es, input m_stage_t ms);
        return r != 5'd0 && tuse != TUSE_NEVER &&
               ((es.waddr == r && es.tnew > tuse) || (ms.waddr == r && ms.tnew > tuse));
    endfunction

    // Nearest ready producer wins; use_e/use_m drop stages not upstream of the consumer.
    function automatic logic [1:0] fwd_src(input logic [4:0] r, input logic use_e, input logic use_m,
                                           input e_stage_t es, input m_stage_t ms, input logic [4:0] ww);
        return r == 5'd0 ? FWD_GRF
             : use_e && es.waddr == r && es.tnew == 3'd0 ? FWD_E
             : use_m && ms.waddr == r && ms.tnew == 3'd0 ? FWD_M
             : ww == r ? FWD_W : FWD_GRF;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e       <= '0;
            m       <= '0;
            w_waddr <= '0;
        end else begin
            e       <= hz.stall ? '0 : e_stage_t'({hz.d_waddr, dec_sat(hz.d_tnew), hz.d_raddr0, hz.d_raddr1});
            m       <= m_stage_t'({e.waddr, dec_sat(e.tnew), e.raddr1});
            w_waddr <= m.waddr;
        end
    end

    assign data_stall  = op_stall(hz.d_raddr0, hz.d_tuse0, e, m) || op_stall(hz.d_raddr1, hz.d_tuse1, e, m);
    assign hz.stall    = data_stall || md_stall;
    assign hz.fwd_d_rs = fwd_src(hz.d_raddr0, 1'b1, 1'b1, e, m, w_waddr);
    assign hz.fwd_d_rt = fwd_src(hz.d_raddr1, 1'b1, 1'b1, e, m, w_waddr);
    assign hz.fwd_e_rs = fwd_src(e.raddr0, 1'b0, 1'b1, e, m, w_waddr);
    assign hz.fwd_e_rt = fwd_src(e.raddr1, 1'b0, 1'b1, e, m, w_waddr);
    assign hz.fwd_m_rt = fwd_src(m.raddr1, 1'b0, 1'b0, e, m, w_waddr);

`ifdef HAZARD_MD_EN
    assign hz.md_start = (hz.d_md_op == MD_MULT || hz.d_md_op == MD_DIV) && !hz.stall;
    assign md_stall    = hz.d_md_use && hz.md_busy;
    md_busy_cnt #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy_cnt (
        .clk  (clk),
        .reset(reset),
        .start(hz.md_start),
        .op   (hz.d_md_op),
        .busy (hz.md_busy)
    );
`else
    localparam int unused_md_cfg = MULT_CYCLES + DIV_CYCLES + CNT_W;
    logic unused_md_in;
    assign unused_md_in = ^{hz.d_md_op, hz.d_md_use};
    assign hz.md_start  = 1'b0;
    assign hz.md_busy   = 1'b0;
    assign md_stall     = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed pipeline scenarios plus randomized traffic against an age-indexed reference model.
module tb_hazard_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;
`ifdef HAZARD_MD_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();
    hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (.clk(clk), .reset(reset), .hz(hz));

    int checks = 0;
    int errors = 0;

    // Model: the last three instructions that left D, indexed by age (1 = E, 2 = M, 3 = W).
    logic [4:0] hw [1:3];
    logic [4:0] hr0[1:3];
    logic [4:0] hr1[1:3];
    logic [2:0] ht [1:3];
    int cyc = 0;
    int md_done = 0;
    logic x_stall, x_start, x_busy;
    logic [1:0] x_fdrs, x_fdrt, x_fers, x_fert, x_fmrt;

    function automatic int ready_in(int k);
        return int'(ht[k]) > k ? int'(ht[k]) - k : 0;
    endfunction

    function automatic logic [1:0] producer(logic [4:0] r, int first);
        for (int k = first; k <= 3; k++)
            if (r != 5'd0 && hw[k] == r && ready_in(k) == 0) return 2'(k);
        return 2'd0;
    endfunction

    function automatic logic must_wait(logic [4:0] r, logic [2:0] tuse);
        for (int k = 1; k <= 2; k++)
            if (r != 5'd0 && hw[k] == r && ready_in(k) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int k = 1; k <= 3; k++) begin
            hw[k] = '0; hr0[k] = '0; hr1[k] = '0; ht[k] = '0;
        end
        md_done = 0;
    endtask

    task automatic drive(input logic [4:0] w, input logic [2:0] tn, input logic [4:0] r0, input logic [2:0] t0,
                         input logic [4:0] r1, input logic [2:0] t1, input logic [1:0] op, input logic use_hl);
        @(negedge clk);
        hz.d_waddr = w; hz.d_tnew = tn; hz.d_raddr0 = r0; hz.d_tuse0 = t0;
        hz.d_raddr1 = r1; hz.d_tuse1 = t1; hz.d_md_op = op; hz.d_md_use = use_hl;
        #1;
        x_busy  = MD && cyc < md_done;
        x_stall = must_wait(r0, t0) || must_wait(r1, t1) || (MD && use_hl && x_busy);
        x_start = MD && (op == 2'd1 || op == 2'd2) && !x_stall;
        x_fdrs  = producer(r0, 1);
        x_fdrt  = producer(r1, 1);
        x_fers  = producer(hr0[1], 2);
        x_fert  = producer(hr1[1], 2);
        x_fmrt  = producer(hr1[2], 3);
    endtask

    task automatic tick();
        @(posedge clk);
        if (x_start) md_done = cyc + 1 + (hz.d_md_op == 2'd2 ? DC : MC);
        cyc++;
        for (int k = 3; k > 1; k--) begin
            hw[k] = hw[k-1]; hr0[k] = hr0[k-1]; hr1[k] = hr1[k-1]; ht[k] = ht[k-1];
        end
        hw[1]  = x_stall ? 5'd0 : hz.d_waddr;
        ht[1]  = x_stall ? 3'd0 : hz.d_tnew;
        hr0[1] = x_stall ? 5'd0 : hz.d_raddr0;
        hr1[1] = x_stall ? 5'd0 : hz.d_raddr1;
    endtask

    task automatic flush();
        repeat (DC + 2) begin
            drive(0, 0, 0, 7, 0, 7, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset();
        drive(8, 3, 8, 0, 9, 0, 2'd1, 1'b1);
        checks++;
        if (hz.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", hz.stall); end
        checks++;
        if ({hz.fwd_d_rs, hz.fwd_d_rt, hz.fwd_e_rs, hz.fwd_e_rt, hz.fwd_m_rt} !== 10'd0) begin
            errors++; $display("FAIL reset_fwd got=%b exp=0", {hz.fwd_d_rs, hz.fwd_d_rt, hz.fwd_e_rs, hz.fwd_e_rt, hz.fwd_m_rt});
        end
        checks++;
        if (hz.md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy got=%b exp=0", hz.md_busy); end
        checks++;
        if (hz.md_start !== MD) begin errors++; $display("FAIL reset_md_start got=%b exp=%b", hz.md_start, MD); end
        reset = 1'b1;
        tick();
        flush();
    endtask

    task automatic test_alu_branch();
        drive(8, 2, 0, 7, 0, 7, 0, 0);
        tick();
        drive(0, 0, 8, 0, 0, 7, 0, 0);
        checks++;
        if (hz.stall !== 1'b1) begin errors++; $display("FAIL alu_branch_stall got=%b exp=1", hz.stall); end
        tick();
        drive(0, 0, 8, 0, 0, 7, 0, 0);
        checks++;
        if (hz.stall !== 1'b0) begin errors++; $display("FAIL alu_branch_release got=%b exp=0", hz.stall); end
        checks++;
        if (hz.fwd_d_rs !== 2'd2) begin errors++; $display("FAIL alu_branch_fwd got=%0d exp=2", hz.fwd_d_rs); end
        tick();
        flush();
    endtask

    task automatic test_load_use();
        drive(8, 3, 0, 7, 0, 7, 0, 0);
        tick();
        drive(9, 2, 8, 1, 0, 7, 0, 0);
        checks++;
        if (hz.stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got=%b exp=1", hz.stall); end
        tick();
        drive(9, 2, 8, 1, 0, 7, 0, 0);
        checks++;
        if (hz.stall !== 1'b0) begin errors++; $display("FAIL load_use_release got=%b exp=0", hz.stall); end
        tick();
        drive(0, 0, 0, 7, 0, 7, 0, 0);
        checks++;
        if (hz.fwd_e_rs !== 2'd3) begin errors++; $display("FAIL load_use_fwd_e got=%0d exp=3", hz.fwd_e_rs); end
        tick();
        flush();
    endtask

    task automatic test_jal_jr();
        drive(31, 1, 0, 7, 0, 7, 0, 0);
        tick();
        drive(0, 0, 31, 0, 0, 7, 0, 0);
        checks++;
        if (hz.stall !== 1'b0) begin errors++; $display("FAIL jal_jr_stall got=%b exp=0", hz.stall); end
        checks++;
        if (hz.fwd_d_rs !== 2'd1) begin errors++; $display("FAIL jal_jr_fwd got=%0d exp=1", hz.fwd_d_rs); end
        tick();
        flush();
    endtask

    task automatic test_zero_reg();
        drive(0, 3, 0, 7, 0, 7, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (hz.stall !== 1'b0) begin errors++; $display("FAIL zero_reg_stall got=%b exp=0", hz.stall); end
        checks++;
        if ({hz.fwd_d_rs, hz.fwd_d_rt} !== 4'd0) begin errors++; $display("FAIL zero_reg_fwd got=%b exp=0", {hz.fwd_d_rs, hz.fwd_d_rt}); end
        tick();
        flush();
    endtask

    task automatic test_mult_mflo();
        int n = 0;
        bit issued = 1'b0;
        drive(0, 0, 1, 1, 2, 1, 2'd3, 1'b0);
        checks++;
        if (hz.md_start !== 1'b0) begin errors++; $display("FAIL md_op3_start got=%b exp=0", hz.md_start); end
        tick();
        drive(0, 0, 1, 1, 2, 1, 2'd1, 1'b1);
        checks++;
        if (hz.md_start !== MD || hz.md_busy !== 1'b0) begin
            errors++; $display("FAIL mult_issue got start=%b busy=%b exp start=%b busy=0", hz.md_start, hz.md_busy, MD);
        end
        tick();
        for (int i = 0; i < MC + 3 && !issued; i++) begin
            drive(3, 2, 0, 7, 0, 7, 2'd0, 1'b1);
            if (hz.stall) begin
                n++;
                checks++;
                if (hz.md_busy !== 1'b1) begin errors++; $display("FAIL mflo_busy got=%b exp=1", hz.md_busy); end
            end else issued = 1'b1;
            tick();
        end
        checks++;
        if (!issued || n != (MD ? MC : 0)) begin
            errors++; $display("FAIL mflo_stall_cycles got=%0d issued=%0d exp=%0d", n, issued, MD ? MC : 0);
        end
        flush();
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 7, 0, 7, 2'd2, 1'b1);
        tick();
        repeat (3) begin
            drive(0, 0, 0, 7, 0, 7, 0, 0);
            tick();
        end
        drive(8, 3, 0, 7, 0, 7, 0, 0);
        tick();
        drive(0, 0, 8, 0, 8, 0, 0, 1'b1);
        checks++;
        if (hz.stall !== 1'b1 || hz.md_busy !== MD) begin
            errors++; $display("FAIL pre_reset got stall=%b busy=%b exp stall=1 busy=%b", hz.stall, hz.md_busy, MD);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({hz.stall, hz.md_busy} !== 2'b00) begin errors++; $display("FAIL mid_reset_stall_busy got=%b exp=00", {hz.stall, hz.md_busy}); end
        checks++;
        if ({hz.fwd_d_rs, hz.fwd_d_rt, hz.fwd_e_rs, hz.fwd_e_rt, hz.fwd_m_rt} !== 10'd0) begin
            errors++; $display("FAIL mid_reset_fwd got=%b exp=0", {hz.fwd_d_rs, hz.fwd_d_rt, hz.fwd_e_rs, hz.fwd_e_rt, hz.fwd_m_rt});
        end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        flush();
    endtask

    task automatic test_random();
        logic [2:0] tuse_set [4] = '{3'd0, 3'd1, 3'd2, 3'd7};
        for (int i = 0; i < 600; i++) begin
            int sel = $urandom_range(0, 19);
            logic [1:0] op = sel == 0 ? 2'd1 : sel == 1 ? 2'd2 : sel == 2 ? 2'd3 : 2'd0;
            logic use_hl = op != 2'd0 || $urandom_range(0, 3) == 0;
            drive(5'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), tuse_set[$urandom_range(0, 3)],
                  5'($urandom_range(0, 3)), tuse_set[$urandom_range(0, 3)], op, use_hl);
            checks++;
            if ({hz.stall, hz.fwd_d_rs, hz.fwd_d_rt, hz.fwd_e_rs, hz.fwd_e_rt, hz.fwd_m_rt, hz.md_start, hz.md_busy}
                !== {x_stall, x_fdrs, x_fdrt, x_fers, x_fert, x_fmrt, x_start, x_busy}) begin
                errors++;
                $display("FAIL random[%0d] {stall,fdrs,fdrt,fers,fert,fmrt,start,busy} got=%b exp=%b", i,
                         {hz.stall, hz.fwd_d_rs, hz.fwd_d_rt, hz.fwd_e_rs, hz.fwd_e_rt, hz.fwd_m_rt, hz.md_start, hz.md_busy},
                         {x_stall, x_fdrs, x_fdrt, x_fers, x_fert, x_fmrt, x_start, x_busy});
            end
            tick();
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_alu_branch();
        test_load_use();
        test_jal_jr();
        test_zero_reg();
        test_mult_mflo();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
